// File: rtl/sram_controller.sv
// sram_controller: services 32-bit MEM-stage loads/stores as two 16-bit async SRAM half-accesses.
// Latency: 2*WAIT_CYCLES+2 cycles per access, read_data valid in the DONE cycle.
// Backpressure: ready low from the request cycle until DONE; inputs are latched once at IDLE exit.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        op_wr;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [31:0] byte_off;
  logic [16:0] word_in;
  logic        unused_off_bits;
  logic        in_phase;
  logic        phase_end;
  logic        req;
  logic        dq_drive;
  logic [15:0] dq_out;

  // Word index wraps modulo 2^17; byte-lane bits and the upper offset are dropped.
  assign byte_off        = address - BASE_ADDR;
  assign word_in         = byte_off[18:2];
  assign unused_off_bits = ^{byte_off[31:19], byte_off[1:0]};

  assign req       = wr_en | rd_en;
  assign in_phase  = (state == LOW) || (state == HIGH);
  assign phase_end = in_phase && (cnt == LAST_CNT);

  assign SRAM_DQ = dq_drive ? dq_out : 16'bz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = ~req;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_drive  = 1'b0;
    dq_out    = wdata[15:0];
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = 4'd0;
        end
      end
      LOW, HIGH: begin
        if (phase_end) begin
          state_nxt = (state == LOW) ? HIGH : DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
        SRAM_WE_N = ~op_wr;
        SRAM_OE_N = op_wr;
        dq_drive  = op_wr;
        dq_out    = (state == HIGH) ? wdata[31:16] : wdata[15:0];
      end
      DONE: begin
        state_nxt = IDLE;
        ready     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM_ADDR is set on phase entry and simply holds outside the phases.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data <= 32'd0;
      SRAM_ADDR <= 18'd0;
      op_wr     <= 1'b0;
      word      <= 17'd0;
      wdata     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr     <= wr_en;
            word      <= word_in;
            wdata     <= write_data;
            SRAM_ADDR <= {word_in, 1'b0};
          end
        end
        LOW: begin
          if (phase_end) begin
            SRAM_ADDR <= {word, 1'b1};
            if (!op_wr) read_data[15:0] <= SRAM_DQ;
          end
        end
        HIGH: begin
          if (phase_end && !op_wr) read_data[31:16] <= SRAM_DQ;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: W=2 and W=1 instances on behavioural async SRAMs, word-level reference model.
module tb_sram_controller;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n;
  logic [15:0] mem [0:262143];

  logic        wr_en1, rd_en1;
  logic [31:0] address1, write_data1, read_data1;
  logic        ready1;
  wire  [15:0] sram_dq1;
  logic [17:0] sram_addr1;
  logic        sram_we_n1, sram_oe_n1;
  logic [15:0] mem1 [0:262143];

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .SRAM_OE_N(sram_oe_n)
  );

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .wr_en(wr_en1), .rd_en(rd_en1),
    .address(address1), .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .SRAM_DQ(sram_dq1), .SRAM_ADDR(sram_addr1), .SRAM_WE_N(sram_we_n1), .SRAM_OE_N(sram_oe_n1)
  );

  // Undriven bus floats to all-ones so a released DQ is observable.
  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup (sram_dq[i]);
    pullup (sram_dq1[i]);
  end

  always @(posedge clock) if (!sram_we_n) mem[sram_addr] <= sram_dq;
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'bz;

  always @(posedge clock) if (!sram_we_n1) mem1[sram_addr1] <= sram_dq1;
  assign sram_dq1 = (!sram_oe_n1 && sram_we_n1) ? mem1[sram_addr1] : 16'bz;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_words [int];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 32'd4) % 32'h20000);
  endfunction

  // One access on the W=2 instance, checking every cycle against the phase timeline.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] data, input bit scramble);
    int          w;
    logic [16:0] wv;
    logic [31:0] exp_rd;
    bit          done;
    bit          hi;
    w      = word_of(addr);
    wv     = 17'(w);
    exp_rd = (!wr && ref_words.exists(w)) ? ref_words[w] : last_rd;
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clock);
      if (ready) begin
        done = 1'b1;
        chk("done_cycle", cyc, 2 * W + 1);
        chk("done_we_n", sram_we_n, 1);
        chk("done_oe_n", sram_oe_n, 1);
        chk(wr ? "rd_hold" : "rd_data", read_data, exp_rd);
      end else if (cyc >= 1) begin
        hi = (cyc > W);
        chk("sram_addr", sram_addr, {wv, hi});
        chk("we_n", sram_we_n, !wr);
        chk("oe_n", sram_oe_n, wr);
        if (wr) chk("dq_wr", sram_dq, hi ? data[31:16] : data[15:0]);
      end
      @(posedge clock); #1;
      if (scramble && cyc == 1) begin
        address    = $urandom;
        write_data = $urandom;
      end
    end
    chk("access_done", done, 1);
    wr_en = 1'b0; rd_en = 1'b0;
    if (wr) begin
      ref_words[w] = data;
      chk("mem_lo", mem[{wv, 1'b0}], data[15:0]);
      chk("mem_hi", mem[{wv, 1'b1}], data[31:16]);
    end else begin
      last_rd = exp_rd;
    end
  endtask

  task automatic access1(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         output int low, output logic [31:0] rdat);
    wr_en1 = wr; rd_en1 = !wr; address1 = addr; write_data1 = data;
    low = 0; rdat = 32'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      if (ready1) begin
        rdat = read_data1;
        break;
      end
      low++;
    end
    @(posedge clock); #1;
    wr_en1 = 1'b0; rd_en1 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          low;
    logic [31:0] rdat;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = 32'd0; write_data1 = 32'd0;
    last_rd = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", ready, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_dq", sram_dq, 16'hFFFF);
    chk("rst_ready1", ready1, 1);
    reset = 1'b0;
    @(posedge clock); #1;

    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    chk("hw0", mem[0], 16'hBEEF);
    chk("hw1", mem[1], 16'hDEAD);
    do_access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1032, 32'h12345678, 1'b0);
    chk("hw4", mem[4], 16'h5678);
    chk("hw5", mem[5], 16'h1234);
    do_access(1'b0, 1'b1, 32'd1024 + 32'h80000, 32'd0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1024 + 32'h80000, 32'h0F1E2D3C, 1'b0);
    chk("wrap_hw0", mem[0], 16'h2D3C);
    do_access(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A, 1'b0);
    chk("prio_hw2", mem[2], 16'h5A5A);
    do_access(1'b1, 1'b0, 32'd1036, 32'h13579BDF, 1'b1);
    do_access(1'b0, 1'b1, 32'd1036, 32'd0, 1'b1);
    do_access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
    do_access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_ready", ready, 1);
      chk("idle_we_n", sram_we_n, 1);
      chk("idle_oe_n", sram_oe_n, 1);
      chk("idle_dq", sram_dq, 16'hFFFF);
    end
    @(posedge clock); #1;

    // Abort a write in its first HIGH cycle.
    address = 32'd1024 + 32'd400; write_data = 32'hCAFEF00D; wr_en = 1'b1;
    repeat (W + 2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_oe_n", sram_oe_n, 1);
    chk("abort_dq", sram_dq, 16'hFFFF);
    chk("abort_rdata", read_data, 0);
    chk("abort_ready_req", ready, 0);
    wr_en = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    last_rd = 32'd0;
    chk("abort_partial_lo", mem[200], 16'hF00D);
    do_access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [16:0] k;
      logic [31:0] a;
      bit          do_wr;
      k     = 17'($urandom_range(0, 7));
      a     = BASE + {13'd0, k, 2'b00} + ($urandom_range(0, 1) == 1 ? 32'h80000 : 32'd0)
              + 32'($urandom_range(0, 3));
      do_wr = ($urandom_range(0, 1) == 1) || !ref_words.exists(int'(k));
      do_access(do_wr, do_wr ? ($urandom_range(0, 1) == 1) : 1'b1, a, $urandom,
                $urandom_range(0, 3) == 0);
    end

    access1(1'b1, 32'd1032, 32'h0BADF00D, low, rdat);
    chk("w1_wr_low", low, 3);
    chk("w1_hw4", mem1[4], 16'hF00D);
    chk("w1_hw5", mem1[5], 16'h0BAD);
    access1(1'b0, 32'd1032, 32'd0, low, rdat);
    chk("w1_rd_low", low, 3);
    chk("w1_rd_data", rdat, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
